aq_ifu_ipack_rd_ctrl: RTL and testbench
=======================================

Name: aq_ifu_ipack_rd_ctrl

Overview:
- Read-side controller for the IFU instruction package buffer.
- Tracks the buffer head with a one-hot read pointer and issues the head entry's instruction and fault bits to IDU through a one-entry output register.
- Generates the per-entry retire pulses that free buffer entries; the write side owns entry creation.
- Sits between the ipack buffer entries and the IDU decode stage.

Parameters:
- ENTRY_NUM, 4, number of ipack buffer entries; must be ≥2.

Ports:
- forever_cpuclk  input  1  free-running core clock
- cpurst_b  input  1  asynchronous active-low reset
- ipack_buf_flush  input  1  pipeline flush; clears reader state
- ipack_entry_vld  input  ENTRY_NUM  per-entry valid
- ipack_entry_inst  input  32*ENTRY_NUM  per-entry instruction; entry i occupies bits [32i+31:32i]
- ipack_entry_acc_err  input  ENTRY_NUM  per-entry access fault
- ipack_entry_pgflt  input  ENTRY_NUM  per-entry page fault
- idu_ifu_id_stall  input  1  IDU cannot accept the output register this cycle
- ipack_entry_retire_en  output  ENTRY_NUM  one-hot retire pulse to the buffer entries
- ipack_rd_ptr  output  ENTRY_NUM  one-hot head pointer
- ifu_idu_id_inst_vld  output  1  output register valid
- ifu_idu_id_inst  output  32  issued instruction
- ifu_idu_id_acc_err  output  1  issued access fault
- ifu_idu_id_pgflt  output  1  issued page fault

Behaviour:
- Single clock domain: forever_cpuclk. cpurst_b is async active-low.
- Reset values:
  - rd_ptr = 1 (entry 0)
  - state = RUN
  - ifu_idu_id_inst_vld = 0
  - ifu_idu_id_inst = 0
  - ifu_idu_id_acc_err = 0
  - ifu_idu_id_pgflt = 0
  - ipack_entry_retire_en = 0
- head_vld = |(ipack_entry_vld & rd_ptr). Head inst and fault bits are AND-OR muxed by rd_ptr.
- out_free = !ifu_idu_id_inst_vld || !idu_ifu_id_stall.
- issue = head_vld && out_free && state==RUN && !ipack_buf_flush.
- On issue, same cycle:
  - ipack_entry_retire_en = rd_ptr (combinational). Otherwise retire_en = 0.
- On issue, next edge:
  - output register loads head inst, acc_err and pgflt; inst_vld = 1.
  - rd_ptr rotates left by one. Bit ENTRY_NUM-1 wraps to bit 0.
- No issue, output consumed (inst_vld && !stall): inst_vld <= 0. Data fields hold.
- Stalled (inst_vld && stall): all output register fields hold, rd_ptr holds, no retire.
- Issue latency: entry valid at cycle N → retire pulse in cycle N → IDU sees it at cycle N+1.
- Throughput: one instruction per cycle while the head is valid and IDU is not stalled (back-to-back; the output register is refilled in the same cycle it drains).
- Empty (head_vld = 0): no retire, rd_ptr holds. The output register drains normally.
- Full buffer needs no special case; the reader only ever looks at the head.
- Flush:
  - in the flush cycle, retire_en = 0 regardless of head state.
  - next edge: rd_ptr = 1, inst_vld = 0, state = RUN. Data fields may hold.
  - flush has priority over issue, stall and exception state.
- State machine:
  - RUN: normal issue.
  - EXPT_WAIT: issue blocked; used only when the optional feature is compiled in.
  - Transitions: RUN → EXPT_WAIT on issue of an entry with acc_err | pgflt (feature only). EXPT_WAIT → RUN on flush only.
- Reset mid-operation: asynchronous return to reset values. Any retire pulse in flight is dropped.
- rd_ptr is always exactly one-hot. A non-one-hot value is a design error; assertion in the bench.

Optional Feature:
- Macro: AQ_IFU_IPACK_RD_EXPT_BLOCK_EN.
- Defined: after issuing a faulting entry the reader enters EXPT_WAIT. No further issue or retire until ipack_buf_flush. The faulting instruction still drains to IDU normally.
- Undefined: the state register is not implemented (reader is always RUN). Faulting entries are issued like any other entry and streaming continues.

Test Plan:
- Reset, then entries 0..3 valid with inst 0x00000013, 0x00100093, 0x00200113, 0x00300193, stall = 0 → retire_en 0001, 0010, 0100, 1000 on consecutive cycles; IDU sees the four insts on the following cycles; rd_ptr wraps to 0001.
- Entry 0 valid, idu_ifu_id_stall = 1 held 3 cycles after the first issue; entry 1 valid → entry 1 is not retired until the cycle stall drops; ifu_idu_id_inst holds 0x00000013 throughout the stall.
- Flush in the same cycle as head_vld = 1 with the output register valid → retire_en = 0; next cycle inst_vld = 0 and rd_ptr = 0001.
- Entry 1 with pgflt = 1, entries 2 and 3 valid, feature defined → entry 1 issued with ifu_idu_id_pgflt = 1; entries 2 and 3 not retired until flush. Same stimulus with feature undefined → entries 2 and 3 retire on the next cycles.
- Assert cpurst_b low mid-stream with inst_vld = 1 → all outputs go to 0 asynchronously; after release, the first retire targets entry 0.

Source files
------------

// File: rtl/aq_ifu_ipack_rd_ctrl_if.sv
// Bus between the ipack buffer entries, the read controller and the IDU decode stage.
// The master side is the buffer/IDU environment; the slave side is the read controller.
interface aq_ifu_ipack_rd_ctrl_if #(
  parameter int ENTRY_NUM = 4
);
  // Buffer entries towards the reader
  logic                   ipack_buf_flush;
  logic [ENTRY_NUM-1:0]   ipack_entry_vld;
  logic [32*ENTRY_NUM-1:0] ipack_entry_inst;
  logic [ENTRY_NUM-1:0]   ipack_entry_acc_err;
  logic [ENTRY_NUM-1:0]   ipack_entry_pgflt;
  logic [ENTRY_NUM-1:0]   ipack_entry_retire_en;
  logic [ENTRY_NUM-1:0]   ipack_rd_ptr;

  // Output register towards IDU
  logic                   idu_ifu_id_stall;
  logic                   ifu_idu_id_inst_vld;
  logic [31:0]            ifu_idu_id_inst;
  logic                   ifu_idu_id_acc_err;
  logic                   ifu_idu_id_pgflt;

  modport master (
    output ipack_buf_flush,
    output ipack_entry_vld,
    output ipack_entry_inst,
    output ipack_entry_acc_err,
    output ipack_entry_pgflt,
    output idu_ifu_id_stall,
    input  ipack_entry_retire_en,
    input  ipack_rd_ptr,
    input  ifu_idu_id_inst_vld,
    input  ifu_idu_id_inst,
    input  ifu_idu_id_acc_err,
    input  ifu_idu_id_pgflt
  );

  modport slave (
    input  ipack_buf_flush,
    input  ipack_entry_vld,
    input  ipack_entry_inst,
    input  ipack_entry_acc_err,
    input  ipack_entry_pgflt,
    input  idu_ifu_id_stall,
    output ipack_entry_retire_en,
    output ipack_rd_ptr,
    output ifu_idu_id_inst_vld,
    output ifu_idu_id_inst,
    output ifu_idu_id_acc_err,
    output ifu_idu_id_pgflt
  );
endinterface

// File: rtl/aq_ifu_ipack_rd_ctrl.sv
// IFU ipack buffer read controller: one-hot head pointer, retire pulses and IDU output register.
// Define AQ_IFU_IPACK_RD_EXPT_BLOCK_EN to stop issuing after a faulting entry until the next flush.
module aq_ifu_ipack_rd_ctrl #(
  parameter int ENTRY_NUM = 4
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  aq_ifu_ipack_rd_ctrl_if.slave bus
);

  logic [ENTRY_NUM-1:0] rd_ptr_q;

  logic                 head_vld;
  logic [31:0]          head_inst;
  logic                 head_acc_err;
  logic                 head_pgflt;

  logic                 out_vld_q;
  logic [31:0]          out_inst_q;
  logic                 out_acc_err_q;
  logic                 out_pgflt_q;

  logic                 out_free;
  logic                 run_ok;
  logic                 issue;

  // ---------------------------------------------------------------------------
  // Head entry selection (AND-OR mux on the one-hot pointer)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path can leave it unassigned and infer a latch.
    head_inst    = '0;
    head_acc_err = 1'b0;
    head_pgflt   = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      head_inst    = head_inst | (bus.ipack_entry_inst[32*i +: 32] & {32{rd_ptr_q[i]}});
      head_acc_err = head_acc_err | (bus.ipack_entry_acc_err[i] & rd_ptr_q[i]);
      head_pgflt   = head_pgflt | (bus.ipack_entry_pgflt[i] & rd_ptr_q[i]);
    end
  end

  assign head_vld = |(bus.ipack_entry_vld & rd_ptr_q);
  assign out_free = !out_vld_q || !bus.idu_ifu_id_stall;

  // Reset is folded in so a retire pulse cannot escape while cpurst_b is low.
  assign issue = head_vld && out_free && run_ok && !bus.ipack_buf_flush && cpurst_b;

  // ---------------------------------------------------------------------------
  // Exception blocking state machine (compiled in only with the feature)
  // ---------------------------------------------------------------------------
`ifdef AQ_IFU_IPACK_RD_EXPT_BLOCK_EN
  typedef enum logic {
    RUN       = 1'b0,
    EXPT_WAIT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (issue && (head_acc_err || head_pgflt)) begin
          state_d = EXPT_WAIT;
        end
      end
      EXPT_WAIT: begin
        if (bus.ipack_buf_flush) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    run_ok = (state_q == RUN);
  end
`else
  // Without the feature the reader never leaves RUN, so no state is kept.
  always_comb begin
    run_ok = 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Head pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every flop samples pre-edge values regardless of block ordering.
      rd_ptr_q <= ENTRY_NUM'(1);
    end else if (bus.ipack_buf_flush) begin
      rd_ptr_q <= ENTRY_NUM'(1);
    end else if (issue) begin
      rd_ptr_q <= {rd_ptr_q[ENTRY_NUM-2:0], rd_ptr_q[ENTRY_NUM-1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Output register towards IDU
  // ---------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      out_vld_q <= 1'b0;
    end else if (bus.ipack_buf_flush) begin
      out_vld_q <= 1'b0;
    end else if (issue) begin
      out_vld_q <= 1'b1;
    end else if (!bus.idu_ifu_id_stall) begin
      out_vld_q <= 1'b0;
    end
  end

  // Data fields only move on issue; a flush or drain leaves them in place.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      out_inst_q    <= '0;
      out_acc_err_q <= 1'b0;
      out_pgflt_q   <= 1'b0;
    end else if (issue) begin
      out_inst_q    <= head_inst;
      out_acc_err_q <= head_acc_err;
      out_pgflt_q   <= head_pgflt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ipack_entry_retire_en = issue ? rd_ptr_q : '0;
  assign bus.ipack_rd_ptr          = rd_ptr_q;
  assign bus.ifu_idu_id_inst_vld   = out_vld_q;
  assign bus.ifu_idu_id_inst       = out_inst_q;
  assign bus.ifu_idu_id_acc_err    = out_acc_err_q;
  assign bus.ifu_idu_id_pgflt      = out_pgflt_q;

endmodule

// File: tb/tb_aq_ifu_ipack_rd_ctrl.sv
// Self-checking bench for aq_ifu_ipack_rd_ctrl: vector table plus scoreboard on the IDU output.
// Expectations follow AQ_IFU_IPACK_RD_EXPT_BLOCK_EN when it is defined for the build.
module tb_aq_ifu_ipack_rd_ctrl;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] acc;
    logic [N-1:0] pg;
    logic         stall;
    logic         flush;
    logic [N-1:0] exp_ret;
    logic [N-1:0] exp_ptr;
    logic         exp_ov;
    logic         chk_inst;
    logic [31:0]  exp_inst;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        acc;
    logic        pg;
  } sb_t;

  logic clk;
  logic rst_n;

  aq_ifu_ipack_rd_ctrl_if #(.ENTRY_NUM(N)) bus ();

  aq_ifu_ipack_rd_ctrl #(.ENTRY_NUM(N)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] inst_tab [N];
  vec_t        vecs[$];
  sb_t         sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [N-1:0] vld, input logic [N-1:0] acc,
                              input logic [N-1:0] pg, input logic stall, input logic flush,
                              input logic [N-1:0] ret, input logic [N-1:0] ptr,
                              input logic ov, input logic chk, input logic [31:0] inst);
    vec_t v;
    v.vld = vld; v.acc = acc; v.pg = pg; v.stall = stall; v.flush = flush;
    v.exp_ret = ret; v.exp_ptr = ptr; v.exp_ov = ov; v.chk_inst = chk; v.exp_inst = inst;
    vecs.push_back(v);
  endfunction

  function automatic void push_entry(input int idx, input logic acc, input logic pg);
    sb_t e;
    e.inst = inst_tab[idx];
    e.acc  = acc;
    e.pg   = pg;
    sb.push_back(e);
  endfunction

  // Scoreboard side: an output is consumed when valid and IDU is not stalling.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_ptr_onehot", 64'($onehot(bus.ipack_rd_ptr)), 64'd1);
      if (bus.ifu_idu_id_inst_vld && !bus.idu_ifu_id_stall && !bus.ipack_buf_flush) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 64'(bus.ifu_idu_id_inst), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("sb_inst_fault",
                64'({bus.ifu_idu_id_inst, bus.ifu_idu_id_acc_err, bus.ifu_idu_id_pgflt}),
                64'(e));
        end
      end
    end
  end

  task automatic apply(input vec_t v, input int idx);
    string tag;
    @(posedge clk);
    #1;
    bus.ipack_entry_vld     = v.vld;
    bus.ipack_entry_acc_err = v.acc;
    bus.ipack_entry_pgflt   = v.pg;
    bus.idu_ifu_id_stall    = v.stall;
    bus.ipack_buf_flush     = v.flush;
    if (v.flush) sb.delete();
    for (int i = 0; i < N; i++) begin
      if (v.exp_ret[i]) push_entry(i, v.acc[i], v.pg[i]);
    end
    @(negedge clk);
    tag = $sformatf("vec%0d", idx);
    check({tag, "_retire"}, 64'(bus.ipack_entry_retire_en), 64'(v.exp_ret));
    check({tag, "_rd_ptr"}, 64'(bus.ipack_rd_ptr), 64'(v.exp_ptr));
    check({tag, "_inst_vld"}, 64'(bus.ifu_idu_id_inst_vld), 64'(v.exp_ov));
    if (v.chk_inst) check({tag, "_inst_hold"}, 64'(bus.ifu_idu_id_inst), 64'(v.exp_inst));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_vld"}, 64'(bus.ifu_idu_id_inst_vld), 64'd0);
    check({tag, "_inst"}, 64'(bus.ifu_idu_id_inst), 64'd0);
    check({tag, "_acc_err"}, 64'(bus.ifu_idu_id_acc_err), 64'd0);
    check({tag, "_pgflt"}, 64'(bus.ifu_idu_id_pgflt), 64'd0);
    check({tag, "_retire"}, 64'(bus.ipack_entry_retire_en), 64'd0);
    check({tag, "_rd_ptr"}, 64'(bus.ipack_rd_ptr), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    inst_tab[0] = 32'h0000_0013;
    inst_tab[1] = 32'h0010_0093;
    inst_tab[2] = 32'h0020_0113;
    inst_tab[3] = 32'h0030_0193;

    rst_n                   = 1'b0;
    bus.ipack_buf_flush     = 1'b0;
    bus.ipack_entry_vld     = 4'b0001;
    bus.ipack_entry_inst    = {inst_tab[3], inst_tab[2], inst_tab[1], inst_tab[0]};
    bus.ipack_entry_acc_err = '0;
    bus.ipack_entry_pgflt   = '0;
    bus.idu_ifu_id_stall    = 1'b0;

    // Reset state, with a valid head that must not be retired while in reset
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    bus.ipack_entry_vld = '0;
    #2 rst_n = 1'b1;

    // Streaming: four back-to-back issues and pointer wrap
    add(4'b1111, 4'b0, 4'b0, 0, 0, 4'b0001, 4'b0001, 0, 1, 32'h0);
    add(4'b1110, 4'b0, 4'b0, 0, 0, 4'b0010, 4'b0010, 1, 1, inst_tab[0]);
    add(4'b1100, 4'b0, 4'b0, 0, 0, 4'b0100, 4'b0100, 1, 1, inst_tab[1]);
    add(4'b1000, 4'b0, 4'b0, 0, 0, 4'b1000, 4'b1000, 1, 1, inst_tab[2]);
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0001, 1, 1, inst_tab[3]);
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0001, 0, 1, inst_tab[3]);
    // Stall held three cycles after the first issue
    add(4'b0001, 4'b0, 4'b0, 0, 0, 4'b0001, 4'b0001, 0, 0, 32'h0);
    add(4'b0010, 4'b0, 4'b0, 1, 0, 4'b0000, 4'b0010, 1, 1, inst_tab[0]);
    add(4'b0010, 4'b0, 4'b0, 1, 0, 4'b0000, 4'b0010, 1, 1, inst_tab[0]);
    add(4'b0010, 4'b0, 4'b0, 1, 0, 4'b0000, 4'b0010, 1, 1, inst_tab[0]);
    add(4'b0010, 4'b0, 4'b0, 0, 0, 4'b0010, 4'b0010, 1, 1, inst_tab[0]);
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0100, 1, 1, inst_tab[1]);
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0100, 0, 0, 32'h0);
    // Flush with a valid head and a valid output register
    add(4'b0100, 4'b0, 4'b0, 0, 0, 4'b0100, 4'b0100, 0, 0, 32'h0);
    add(4'b1000, 4'b0, 4'b0, 0, 1, 4'b0000, 4'b1000, 1, 1, inst_tab[2]);
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0001, 0, 0, 32'h0);
    add(4'b0001, 4'b0, 4'b0, 0, 0, 4'b0001, 4'b0001, 0, 0, 32'h0);
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0010, 1, 1, inst_tab[0]);
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0010, 0, 0, 32'h0);
    // Faulting entry 1 (page fault), entries 2 and 3 behind it
`ifdef AQ_IFU_IPACK_RD_EXPT_BLOCK_EN
    add(4'b1110, 4'b1000, 4'b0010, 0, 0, 4'b0010, 4'b0010, 0, 0, 32'h0);
    add(4'b1100, 4'b1000, 4'b0010, 0, 0, 4'b0000, 4'b0100, 1, 1, inst_tab[1]);
    add(4'b1100, 4'b1000, 4'b0010, 0, 0, 4'b0000, 4'b0100, 0, 0, 32'h0);
    add(4'b1100, 4'b1000, 4'b0010, 0, 0, 4'b0000, 4'b0100, 0, 0, 32'h0);
    add(4'b1100, 4'b1000, 4'b0010, 0, 1, 4'b0000, 4'b0100, 0, 0, 32'h0);
    add(4'b1100, 4'b1000, 4'b0010, 0, 0, 4'b0000, 4'b0001, 0, 0, 32'h0);
`else
    add(4'b1110, 4'b1000, 4'b0010, 0, 0, 4'b0010, 4'b0010, 0, 0, 32'h0);
    add(4'b1100, 4'b1000, 4'b0010, 0, 0, 4'b0100, 4'b0100, 1, 1, inst_tab[1]);
    add(4'b1000, 4'b1000, 4'b0010, 0, 0, 4'b1000, 4'b1000, 1, 1, inst_tab[2]);
    add(4'b0000, 4'b1000, 4'b0010, 0, 0, 4'b0000, 4'b0001, 1, 1, inst_tab[3]);
    add(4'b0000, 4'b1000, 4'b0010, 0, 0, 4'b0000, 4'b0001, 0, 0, 32'h0);
`endif
    add(4'b0000, 4'b0, 4'b0, 0, 0, 4'b0000, 4'b0001, 0, 0, 32'h0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset mid-stream with the output register valid
    @(posedge clk);
    #1;
    bus.ipack_entry_vld  = 4'b0001;
    bus.idu_ifu_id_stall = 1'b0;
    push_entry(0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_pre_retire", 64'(bus.ipack_entry_retire_en), 64'b0001);
    @(posedge clk);
    #1;
    bus.ipack_entry_vld  = 4'b0010;
    bus.idu_ifu_id_stall = 1'b1;
    @(negedge clk);
    check("rst_pre_inst_vld", 64'(bus.ifu_idu_id_inst_vld), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_inst_vld", 64'(bus.ifu_idu_id_inst_vld), 64'd0);
    bus.ipack_entry_vld  = '0;
    bus.idu_ifu_id_stall = 1'b0;
    #2 rst_n = 1'b1;

    @(posedge clk);
    #1;
    bus.ipack_entry_vld = 4'b0011;
    push_entry(0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_post_retire0", 64'(bus.ipack_entry_retire_en), 64'b0001);
    @(posedge clk);
    #1;
    bus.ipack_entry_vld = 4'b0010;
    push_entry(1, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_post_retire1", 64'(bus.ipack_entry_retire_en), 64'b0010);
    @(posedge clk);
    #1;
    bus.ipack_entry_vld = '0;
    @(negedge clk);
    check("rst_post_idle_retire", 64'(bus.ipack_entry_retire_en), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_post_drained", 64'(bus.ifu_idu_id_inst_vld), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
